// File: rtl/fifo_pkg.sv
// fifo_pkg: shared word-width default and buffer count type for the read-side stream.
package fifo_pkg;
   localparam int DATA_W_DEF = 8;
   typedef logic [1:0] cnt_t;
endpackage

// File: rtl/fifo_rd_buf2.sv
// fifo_rd_buf2: 2-entry FIFO storage with head/tail pointers and occupancy count.
module fifo_rd_buf2
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] head_o,
   output cnt_t              count_o
);
   logic [DATA_W-1:0] mem_q [2];
   logic head_q, tail_q;
   cnt_t count_q, count_d;
   always_comb count_d = count_q + cnt_t'(push_i) - cnt_t'(pop_i);
   // A push with a pop writes behind the surviving entry, so order is preserved.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         mem_q   <= '{default: '0};
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= '0;
      end else begin
         if (push_i) mem_q[tail_q] <= din_i;
         tail_q  <= tail_q ^ push_i;
         head_q  <= head_q ^ pop_i;
         count_q <= count_d;
      end
   end
   assign head_o  = mem_q[head_q];
   assign count_o = count_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a 1-cycle-latency FIFO read port into a valid/ready stream
// with a 2-word skid buffer sustaining one word per cycle.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic              empty,
   output logic              r_en,
   input  logic [DATA_W-1:0] rdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output cnt_t              level
);
   logic inflight_q, inflight_d, pop;
   logic [2:0] credit;
   cnt_t count;
   // A read may issue only if its word is guaranteed a free slot when it lands.
   always_comb begin
      pop        = m_valid && m_ready;
      credit     = {1'b0, count} + {2'b0, inflight_q};
      r_en       = rrst_n && !empty && (credit < 3'd2 || pop);
      inflight_d = r_en && !empty;
   end
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) inflight_q <= 1'b0;
      else         inflight_q <= inflight_d;
   end
   fifo_rd_buf2 #(.DATA_W(DATA_W)) u_buf (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .push_i  (inflight_q),
      .pop_i   (pop),
      .din_i   (rdata),
      .head_o  (m_data),
      .count_o (count)
   );
   assign m_valid = count != '0;
   assign level   = count;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed vector table plus reset, streaming and random scoreboard sequences.
module tb_fifo_rd_stream;
   localparam int W = 8;
   typedef struct {
      logic       e;
      logic       r;
      logic       ren;
      logic       v;
      logic [7:0] d;
      logic [1:0] l;
   } vec_t;
   logic rclk = 1'b0, rrst_n = 1'b0, empty = 1'b1, m_ready = 1'b0;
   logic r_en, m_valid;
   logic [W-1:0] rdata = 8'hEE, m_data;
   logic [1:0] level;
   logic [W-1:0] mem [0:16383];
   int ptr = 0, sb_idx = 0, n_chk = 0, n_fail = 0;
   logic acc = 1'b0, infl = 1'b0;
   logic s_ren, s_valid;
   logic [7:0] s_data;
   logic [1:0] s_level;
   vec_t tbl [19];

   always #5 rclk = ~rclk;

   fifo_rd_stream #(.DATA_W(W)) dut (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .empty   (empty),
      .r_en    (r_en),
      .rdata   (rdata),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .level   (level)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive inputs, sample at negedge, model the 1-cycle memory read.
   task automatic cyc(input logic e, input logic r);
      empty   = e;
      m_ready = r;
      @(negedge rclk);
      s_ren   = r_en;
      s_valid = m_valid;
      s_data  = m_data;
      s_level = level;
      infl    = acc;
      acc     = rrst_n && r_en && !empty;
      @(posedge rclk);
      #1;
      if (acc) begin
         rdata = mem[ptr];
         ptr++;
      end else rdata = 8'hEE;
   endtask

   task automatic sb_step();
      chk("invariant", 32'(int'(s_level) + int'(infl) <= 2), 32'd1);
      if (s_valid && m_ready) begin
         chk("order", {24'd0, s_data}, {24'd0, mem[sb_idx]});
         sb_idx++;
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
      tbl = '{
         '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0},
         '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0},
         '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0},
         '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd1},
         '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0},
         '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 2'd1},
         '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 2'd2},
         '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 2'd2},
         '{1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 2'd2},
         '{1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 2'd1},
         '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 2'd1},
         '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0},
         '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0},
         '{1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 2'd1},
         '{1'b1, 1'b1, 1'b0, 1'b1, 8'h21, 2'd1},
         '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0}
      };
      // Reset state, with empty low to show r_en is still forced off.
      empty = 1'b0;
      repeat (2) @(posedge rclk);
      #1;
      chk("rst r_en", 32'(r_en), 32'd0);
      chk("rst m_valid", 32'(m_valid), 32'd0);
      chk("rst m_data", 32'(m_data), 32'd0);
      chk("rst level", 32'(level), 32'd0);
      rrst_n = 1'b1;
      empty  = 1'b1;
      // Single word, backpressure, and land/pop collision vectors.
      mem[ptr]     = 8'hA5;
      mem[ptr + 1] = 8'h01;
      mem[ptr + 2] = 8'h02;
      mem[ptr + 3] = 8'h03;
      mem[ptr + 4] = 8'h20;
      mem[ptr + 5] = 8'h21;
      for (int i = 0; i < 19; i++) begin
         cyc(tbl[i].e, tbl[i].r);
         chk($sformatf("vec%0d r_en", i), 32'(s_ren), 32'(tbl[i].ren));
         chk($sformatf("vec%0d m_valid", i), 32'(s_valid), 32'(tbl[i].v));
         chk($sformatf("vec%0d level", i), 32'(s_level), 32'(tbl[i].l));
         if (tbl[i].v) chk($sformatf("vec%0d m_data", i), 32'(s_data), 32'(tbl[i].d));
      end
      // Streaming: ten words, no bubbles after the 2-cycle fill.
      for (int k = 0; k < 10; k++) mem[ptr + k] = 8'(8'h10 + k);
      for (int k = 0; k < 13; k++) begin
         cyc(k >= 10, 1'b1);
         chk($sformatf("stream%0d r_en", k), 32'(s_ren), 32'(k < 10));
         chk($sformatf("stream%0d m_valid", k), 32'(s_valid), 32'(k >= 2 && k <= 11));
         if (k >= 2 && k <= 11) chk($sformatf("stream%0d m_data", k), 32'(s_data), 32'(8'h10 + k - 2));
      end
      // Mid-operation reset with a full buffer and a read being issued.
      repeat (4) cyc(1'b0, 1'b0);
      chk("pre-rst level", 32'(s_level), 32'd2);
      empty   = 1'b0;
      m_ready = 1'b1;
      @(negedge rclk);
      chk("pre-rst r_en", 32'(r_en), 32'd1);
      rrst_n = 1'b0;
      #1;
      chk("mid-rst m_valid", 32'(m_valid), 32'd0);
      chk("mid-rst level", 32'(level), 32'd0);
      chk("mid-rst r_en", 32'(r_en), 32'd0);
      chk("mid-rst m_data", 32'(m_data), 32'd0);
      repeat (2) @(posedge rclk);
      #1;
      rrst_n = 1'b1;
      empty  = 1'b1;
      acc    = 1'b0;
      rdata  = 8'hEE;
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b1);
         chk($sformatf("post-rst%0d m_valid", k), 32'(s_valid), 32'd0);
         chk($sformatf("post-rst%0d level", k), 32'(s_level), 32'd0);
         chk($sformatf("post-rst%0d r_en", k), 32'(s_ren), 32'd0);
      end
      // Random empty/m_ready against a memory-order scoreboard, then drain.
      sb_idx = ptr;
      for (int i = 0; i < 10000; i++) begin
         cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
         sb_step();
      end
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b1);
         sb_step();
      end
      chk("drain count", 32'(sb_idx), 32'(ptr));
      chk("drain m_valid", 32'(s_valid), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the FIFO word width in bits.
REQ-002 SHALL have port rclk, input, 1, read-domain clock; all state rising-edge.
REQ-003 SHALL have port rrst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port empty, input, 1, FIFO empty flag from the read-pointer block, synchronous to rclk.
REQ-005 SHALL have port r_en, output, 1, read request to the read-pointer block and memory.
REQ-006 SHALL have port rdata, input, DATA_W, memory read data, valid exactly one rclk cycle after an accepted read.
REQ-007 SHALL have port m_valid, output, 1, downstream data valid.
REQ-008 SHALL have port m_ready, input, 1, downstream ready.
REQ-009 SHALL have port m_data, output, DATA_W, downstream data, the head of the buffer.
REQ-010 SHALL have port level, output, 2, number of buffered words (0..2).

Function
REQ-011 SHALL treat a read as accepted in cycle N when r_en=1 and empty=0; its word SHALL be captured from rdata at the rclk edge ending cycle N+1.
REQ-012 SHALL hold a 2-entry FIFO buffer, a count (0..2) and an inflight bit (one accepted read awaiting data).
REQ-013 SHALL define pop = m_valid && m_ready, and credit = count + inflight.
REQ-014 SHALL drive r_en = !empty && (credit < 2 || pop), combinationally.
REQ-015 SHALL maintain the invariant count + inflight <= 2 at every edge, so a landing word never overflows the buffer.
REQ-016 SHALL drive m_valid = (count != 0).
REQ-017 SHALL drive m_data from the head entry.
REQ-018 SHALL drive level = count.
REQ-019 SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-020 SHALL, for a simultaneous land and pop, hold count constant and write the landed word behind the remaining entry, preserving FIFO order.
REQ-021 SHALL, for a land with no pop, increment count; for a pop with no land, decrement count and advance the head.
REQ-022 SHALL set inflight to the value of the accepted-read condition (r_en && !empty) on each edge.
REQ-023 SHALL sustain one word per cycle with m_ready held at 1 and empty held at 0, after an initial 2-cycle fill latency (read issue to m_valid).
REQ-024 SHALL not combinationally pass m_ready through to m_valid; m_valid is a register-derived output.

Reset
REQ-025 SHALL, while rrst_n=0, force count=0, inflight=0, both buffer entries=0, m_valid=0, m_data=0, level=0 and r_en=0, regardless of empty.
REQ-026 SHALL, on reset assertion mid-transfer, discard buffered and in-flight words; no stale word is presented after reset release.
REQ-027 SHALL release from reset synchronously to rclk (deassertion handled by the existing reset synchronizer) and issue no read before the first post-reset edge.

Structure
REQ-028 SHALL use a shared package fifo_pkg holding the DATA_W default (8) and a 2-bit typedef for buffer count/level.
REQ-029 SHALL instantiate exactly one sub-module, fifo_rd_buf2: the 2-entry storage with head/tail pointers, push/pop, and count.
REQ-030 SHALL keep all issue logic (r_en, inflight, credit) in fifo_rd_stream; the module lies entirely in the rclk domain.

Verification
REQ-031 SHALL cover single word: empty 1->0 with word 0xA5 on rdata one cycle after r_en, m_ready=1 -> r_en for 1 cycle, m_valid=1 with m_data=0xA5 2 cycles after r_en, then level returns to 0.
REQ-032 SHALL cover backpressure: m_ready=0, empty=0, words 0x01,0x02,0x03 available -> exactly 2 reads issued, level=2, r_en=0, m_data=0x01 held stable.
REQ-033 SHALL cover streaming: m_ready=1, empty=0 for 10 cycles, words 0x10..0x19 -> m_data 0x10..0x19 on consecutive cycles, no bubbles after fill.
REQ-034 SHALL cover a land/pop collision: level=1 holding 0x20, a read in flight returning 0x21, pop same cycle -> level stays 1, next m_data=0x21.
REQ-035 SHALL cover mid-operation reset: level=2 plus a read in flight, assert rrst_n=0 -> m_valid=0, level=0, r_en=0 immediately; after release with empty=1, outputs stay idle.
REQ-036 SHALL cover random m_ready and empty for 10k cycles with a scoreboard: output order equals memory order, no loss or duplication, and count + inflight <= 2 always.
